// File: rtl/tcm_bankctl.sv
// tcm_bankctl: Cortex-M7 TCM host port to NB interleaved 9-bit-per-byte SRAM banks, with wait states and parity
// Ports: clk/reset (async high); host side cs_i, addr_i, we_i, wd_i, waitcyc_i, even_i -> rd_o, wait_o, err_o;
// bank side ram_cs_o (one-hot), ram_addr_o, ram_we_o, ram_wd_o ({byte,parity} per byte) <- ram_rd_i (1-cycle SRAM).
// Optional background scrubber: define TCM_BANKCTL_SCRUB_EN to add scrub_en_i, scrub_errcnt_o, scrub_erraddr_o, scrub_wrap_o.
module tcm_bankctl #(
  parameter int AW = 13,
  parameter int DW = 32,
  parameter int NB = 2,
  parameter int RDW = 2,
  parameter int PW = DW / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     even_i,
  input  logic [RDW-1:0]           waitcyc_i,
  input  logic                     cs_i,
  input  logic [AW-1:0]            addr_i,
  input  logic [DW/8-1:0]          we_i,
  input  logic [DW-1:0]            wd_i,
  output logic [DW-1:0]            rd_o,
  output logic                     wait_o,
  output logic                     err_o,
  output logic [NB-1:0]            ram_cs_o,
  output logic [AW-(NB > 1 ? $clog2(NB) : 0)-1:0] ram_addr_o,
  output logic [DW/8-1:0]          ram_we_o,
  output logic [DW+PW-1:0]         ram_wd_o,
`ifdef TCM_BANKCTL_SCRUB_EN
  input  logic                     scrub_en_i,
  output logic [15:0]              scrub_errcnt_o,
  output logic [AW-1:0]            scrub_erraddr_o,
  output logic                     scrub_wrap_o,
`endif
  input  logic [NB*(DW+PW)-1:0]    ram_rd_i
);
  localparam int BW = NB > 1 ? $clog2(NB) : 0;
  localparam int SW = BW > 0 ? BW : 1;
  localparam int RW = DW + PW;
  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;
  state_t state, state_n;
  logic [RDW-1:0] cnt;
  logic [SW-1:0] bank_q;
  logic rd_q, even_q;
  logic [AW-1:0] addr_q;
  logic [PW-1:0] we_q;
  logic [DW-1:0] wd_q;
  logic host_ph, drive, scrub_go, rd_phase, a_ev;
  logic [AW-1:0] a_addr, scrub_addr;
  logic [PW-1:0] a_we;
  logic [RW-1:0] hw;
  function automatic logic par(input logic [7:0] b, input logic ev);
    return ev ? ^b : ~^b;
  endfunction
  function automatic logic [SW-1:0] bank_of(input logic [AW-1:0] a);
    return NB > 1 ? a[SW-1:0] : '0;
  endfunction
  function automatic logic [RW-1:0] enc(input logic [DW-1:0] d, input logic ev);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < PW; i++) r[9*i +: 9] = {d[8*i +: 8], par(d[8*i +: 8], ev)};
    return r;
  endfunction
  function automatic logic [DW-1:0] strip(input logic [RW-1:0] w);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < PW; i++) r[8*i +: 8] = w[9*i+1 +: 8];
    return r;
  endfunction
  function automatic logic chk(input logic [RW-1:0] w, input logic ev);
    logic e;
    e = 1'b0;
    for (int i = 0; i < PW; i++) e |= w[9*i] != par(w[9*i+1 +: 8], ev);
    return e;
  endfunction
  // cs_i is an address phase only outside WAIT; in DATA it overlaps the next access
  assign host_ph = cs_i && state != WAIT;
  assign drive = host_ph || state == WAIT || scrub_go;
  assign a_addr = host_ph ? addr_i : state == WAIT ? addr_q : scrub_addr;
  assign a_we = host_ph ? we_i : state == WAIT ? we_q : '0;
  assign a_ev = host_ph ? even_i : state == WAIT ? even_q : even_i;
  assign ram_cs_o = drive ? NB'(1) << bank_of(a_addr) : '0;
  assign ram_addr_o = a_addr[AW-1:BW];
  assign ram_we_o = drive ? a_we : '0;
  assign ram_wd_o = enc(host_ph ? wd_i : wd_q, a_ev);
  assign hw = ram_rd_i[bank_q*RW +: RW];
  assign rd_phase = state == DATA && rd_q;
  assign rd_o = rd_phase ? strip(hw) : '0;
  assign err_o = rd_phase && chk(hw, even_q);
  assign wait_o = state == WAIT;
  always_comb begin
    state_n = IDLE;
    if (host_ph) state_n = waitcyc_i == '0 ? DATA : WAIT;
    else if (state == WAIT) state_n = cnt == RDW'(1) ? DATA : WAIT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bank_q <= '0;
      rd_q <= 1'b0;
      even_q <= 1'b0;
      addr_q <= '0;
      we_q <= '0;
      wd_q <= '0;
    end else begin
      state <= state_n;
      if (host_ph) begin
        cnt <= waitcyc_i;
        bank_q <= bank_of(addr_i);
        rd_q <= we_i == '0;
        even_q <= even_i;
        addr_q <= addr_i;
        we_q <= we_i;
        wd_q <= wd_i;
      end else if (state == WAIT) cnt <= cnt - RDW'(1);
    end
  end
`ifdef TCM_BANKCTL_SCRUB_EN
  logic [AW-1:0] scrub_aq;
  logic [SW-1:0] scrub_bank;
  logic scrub_q, scrub_ev, scrub_seen;
  // scrubbing only steals idle host slots, so a scrub result is never in flight with a host read
  assign scrub_go = state != WAIT && !cs_i && scrub_en_i && waitcyc_i == '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scrub_addr <= '0;
      scrub_aq <= '0;
      scrub_bank <= '0;
      scrub_q <= 1'b0;
      scrub_ev <= 1'b0;
      scrub_seen <= 1'b0;
      scrub_errcnt_o <= '0;
      scrub_erraddr_o <= '0;
      scrub_wrap_o <= 1'b0;
    end else begin
      scrub_q <= scrub_go;
      scrub_wrap_o <= scrub_go && scrub_addr == '1;
      if (scrub_go) begin
        scrub_addr <= scrub_addr + AW'(1);
        scrub_aq <= scrub_addr;
        scrub_bank <= bank_of(scrub_addr);
        scrub_ev <= even_i;
      end
      if (scrub_q && chk(ram_rd_i[scrub_bank*RW +: RW], scrub_ev)) begin
        if (scrub_errcnt_o != '1) scrub_errcnt_o <= scrub_errcnt_o + 16'd1;
        if (!scrub_seen) begin
          scrub_erraddr_o <= scrub_aq;
          scrub_seen <= 1'b1;
        end
      end
    end
  end
`else
  assign scrub_go = 1'b0;
  assign scrub_addr = '0;
`endif
endmodule

// File: tb/tb_tcm_bankctl.sv
// tb_tcm_bankctl: randomized self-checking bench for tcm_bankctl with a two-bank SRAM model
module tb_tcm_bankctl;
  logic clk = 1'b0, reset = 1'b1, even_i = 1'b1, cs_i = 1'b0;
  logic [1:0] waitcyc_i = '0;
  logic [12:0] addr_i = '0;
  logic [3:0] we_i = '0;
  logic [31:0] wd_i = '0;
  logic [31:0] rd_o;
  logic wait_o, err_o;
  logic [1:0] ram_cs_o;
  logic [11:0] ram_addr_o;
  logic [3:0] ram_we_o;
  logic [35:0] ram_wd_o;
  logic [71:0] ram_rd_i;
  logic [35:0] mem [2][4096];
  logic [35:0] rdat [2];
  logic mem_clr = 1'b1, flip_req = 1'b0;
  logic [12:0] flip_addr = '0;
  logic [31:0] m_data [8192];
  logic [3:0] m_ev [8192];
  logic [3:0] m_bad [8192];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign ram_rd_i = {rdat[1], rdat[0]};
  tcm_bankctl dut (
    .clk(clk), .reset(reset), .even_i(even_i), .waitcyc_i(waitcyc_i), .cs_i(cs_i),
    .addr_i(addr_i), .we_i(we_i), .wd_i(wd_i), .rd_o(rd_o), .wait_o(wait_o), .err_o(err_o),
    .ram_cs_o(ram_cs_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wd_o(ram_wd_o),
    .ram_rd_i(ram_rd_i)
  );
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int b = 0; b < 2; b++) for (int i = 0; i < 4096; i++) mem[b][i] <= '0;
    end else if (flip_req) mem[flip_addr[0]][flip_addr[12:1]][18] <= ~mem[flip_addr[0]][flip_addr[12:1]][18];
    for (int b = 0; b < 2; b++) if (ram_cs_o[b]) begin
      rdat[b] <= mem[b][ram_addr_o];
      for (int k = 0; k < 4; k++) if (ram_we_o[k]) mem[b][ram_addr_o][9*k +: 9] <= ram_wd_o[9*k +: 9];
    end
  end
  task automatic model_write(input logic [12:0] a, input logic [3:0] we, input logic [31:0] wd, input logic ev);
    for (int k = 0; k < 4; k++) if (we[k]) begin
      m_data[a][8*k +: 8] = wd[8*k +: 8];
      m_ev[a][k] = ev;
      m_bad[a][k] = 1'b0;
    end
  endtask
  function automatic logic exp_err(input logic [12:0] a, input logic ev);
    return |((m_ev[a] ^ {4{ev}}) ^ m_bad[a]);
  endfunction
  task automatic host_op(input logic [12:0] a, input logic [3:0] we, input logic [31:0] wd, input logic [1:0] wc,
                         input logic ev, output logic [31:0] rd, output logic e, output int waits,
                         output logic [1:0] cs0, output logic [11:0] la0, output logic held);
    @(negedge clk);
    cs_i = 1'b1; addr_i = a; we_i = we; wd_i = wd; waitcyc_i = wc; even_i = ev;
    #1 cs0 = ram_cs_o; la0 = ram_addr_o; held = 1'b1;
    @(negedge clk);
    cs_i = 1'b0; waitcyc_i = 2'($urandom); even_i = 1'($urandom); addr_i = 13'($urandom); we_i = 4'($urandom);
    waits = 0;
    while (wait_o === 1'b1 && waits < 20) begin
      held &= ram_cs_o === cs0;
      waits++;
      @(negedge clk);
    end
    rd = rd_o; e = err_o;
    if (we != 0) model_write(a, we, wd, ev);
    we_i = '0;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    checks++;
    if ({rd_o, wait_o, err_o, ram_cs_o, ram_we_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%h wait=%b err=%b cs=%b we=%b, want all 0", rd_o, wait_o, err_o, ram_cs_o, ram_we_o);
    end
    @(negedge clk) reset = 1'b0;
  endtask
  task automatic test_basic;
    logic [31:0] rd; logic e, h; int w; logic [1:0] c; logic [11:0] la;
    host_op(13'h10, 4'hF, 32'hA5A5_0001, 2'd0, 1'b1, rd, e, w, c, la, h);
    checks++;
    if (rd !== 0 || e !== 0 || w !== 0) begin errors++; $display("FAIL basic_write: rd=%h err=%b waits=%0d, want 0 0 0", rd, e, w); end
    host_op(13'h10, 4'h0, 32'h0, 2'd0, 1'b1, rd, e, w, c, la, h);
    checks++;
    if (c !== 2'b01 || la !== 12'h8) begin errors++; $display("FAIL basic_decode: cs=%b addr=%h, want 01 008", c, la); end
    checks++;
    if (rd !== 32'hA5A5_0001 || e !== 0 || w !== 0) begin errors++; $display("FAIL basic_read: rd=%h err=%b waits=%0d, want a5a50001 0 0", rd, e, w); end
  endtask
  task automatic test_wait;
    logic [31:0] rd; logic e, h; int w; logic [1:0] c; logic [11:0] la;
    host_op(13'h11, 4'hF, 32'h1357_9BDF, 2'd1, 1'b1, rd, e, w, c, la, h);
    host_op(13'h11, 4'h0, 32'h0, 2'd3, 1'b1, rd, e, w, c, la, h);
    checks++;
    if (w !== 3 || !h || c !== 2'b10) begin errors++; $display("FAIL wait_phase: waits=%0d held=%b cs=%b, want 3 1 10", w, h, c); end
    checks++;
    if (rd !== 32'h1357_9BDF || e !== 0) begin errors++; $display("FAIL wait_read: rd=%h err=%b, want 13579bdf 0", rd, e); end
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) model_write(13'(i), 4'hF, 32'hC0DE_0000 + i, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cs_i = 1'b1; addr_i = 13'(i); we_i = 4'hF; wd_i = 32'hC0DE_0000 + i; waitcyc_i = 0; even_i = 1'b1;
    end
    @(negedge clk);
    cs_i = 1'b1; we_i = 4'h0; addr_i = 13'd0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        checks++;
        if (rd_o !== m_data[i-1] || wait_o !== 0 || err_o !== 0) begin
          errors++; $display("FAIL b2b_read%0d: rd=%h wait=%b err=%b, want %h 0 0", i - 1, rd_o, wait_o, err_o, m_data[i-1]);
        end
      end
      if (i < 4) begin
        addr_i = 13'(i);
        #1 checks++;
        if (ram_cs_o !== 2'(1 << (i % 2))) begin errors++; $display("FAIL b2b_bank%0d: cs=%b, want %b", i, ram_cs_o, 2'(1 << (i % 2))); end
      end else cs_i = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (rd_o !== 0 || err_o !== 0) begin errors++; $display("FAIL b2b_idle: rd=%h err=%b, want 0 0", rd_o, err_o); end
  endtask
  task automatic test_parity;
    logic [31:0] rd; logic e, h; int w; logic [1:0] c; logic [11:0] la;
    host_op(13'h20, 4'hF, 32'hDEAD_BEEF, 2'd0, 1'b1, rd, e, w, c, la, h);
    @(negedge clk); flip_addr = 13'h20; flip_req = 1'b1;
    @(negedge clk); flip_req = 1'b0;
    m_bad[13'h20][2] = 1'b1;
    host_op(13'h20, 4'h0, 32'h0, 2'd0, 1'b1, rd, e, w, c, la, h);
    checks++;
    if (rd !== 32'hDEAD_BEEF || e !== 1'b1) begin errors++; $display("FAIL parity_flip: rd=%h err=%b, want deadbeef 1", rd, e); end
    @(negedge clk);
    checks++;
    if (err_o !== 0) begin errors++; $display("FAIL parity_pulse: err=%b, want 0", err_o); end
    host_op(13'h20, 4'hF, 32'hDEAD_BEEF, 2'd0, 1'b0, rd, e, w, c, la, h);
    host_op(13'h20, 4'h0, 32'h0, 2'd2, 1'b0, rd, e, w, c, la, h);
    checks++;
    if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin errors++; $display("FAIL parity_odd: rd=%h err=%b, want deadbeef 0", rd, e); end
    host_op(13'h20, 4'h0, 32'h0, 2'd0, 1'b1, rd, e, w, c, la, h);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL parity_polarity: err=%b, want 1", e); end
  endtask
  task automatic test_byte_write;
    logic [31:0] rd; logic e, h; int w; logic [1:0] c; logic [11:0] la;
    host_op(13'h33, 4'hF, 32'h1122_3344, 2'd0, 1'b1, rd, e, w, c, la, h);
    host_op(13'h33, 4'b0100, 32'h00FF_0000, 2'd1, 1'b1, rd, e, w, c, la, h);
    host_op(13'h33, 4'h0, 32'h0, 2'd0, 1'b1, rd, e, w, c, la, h);
    checks++;
    if (rd !== 32'h11FF_3344 || e !== 0) begin errors++; $display("FAIL byte_write: rd=%h err=%b, want 11ff3344 0", rd, e); end
  endtask
  task automatic test_reset_in_wait;
    logic [31:0] rd; logic e, h; int w; logic [1:0] c; logic [11:0] la;
    @(negedge clk);
    cs_i = 1'b1; addr_i = 13'h11; we_i = 0; waitcyc_i = 2'd3; even_i = 1'b1;
    @(negedge clk); cs_i = 1'b0;
    @(negedge clk); reset = 1'b1;
    #1 checks++;
    if ({rd_o, wait_o, err_o, ram_cs_o} !== '0) begin
      errors++; $display("FAIL reset_wait: rd=%h wait=%b err=%b cs=%b, want all 0", rd_o, wait_o, err_o, ram_cs_o);
    end
    @(negedge clk); reset = 1'b0;
    host_op(13'h11, 4'h0, 32'h0, 2'd2, 1'b1, rd, e, w, c, la, h);
    checks++;
    if (rd !== m_data[13'h11] || e !== 0 || w !== 2) begin
      errors++; $display("FAIL reset_recover: rd=%h err=%b waits=%0d, want %h 0 2", rd, e, w, m_data[13'h11]);
    end
  endtask
  task automatic test_random;
    logic [31:0] rd, wd; logic e, h, ev, exp_e; int w; logic [1:0] c, wc; logic [11:0] la; logic [12:0] a; logic [3:0] we;
    for (int n = 0; n < 60; n++) begin
      a = 13'($urandom_range(0, 63));
      we = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      wd = $urandom; wc = 2'($urandom); ev = 1'($urandom);
      exp_e = exp_err(a, ev);
      host_op(a, we, wd, wc, ev, rd, e, w, c, la, h);
      checks++;
      if (we == 0 && (rd !== m_data[a] || e !== exp_e)) begin
        errors++; $display("FAIL rand_read%0d @%h: rd=%h err=%b, want %h %b", n, a, rd, e, m_data[a], exp_e);
      end else if (we != 0 && (rd !== 0 || e !== 0)) begin
        errors++; $display("FAIL rand_write%0d @%h: rd=%h err=%b, want 0 0", n, a, rd, e);
      end
      checks++;
      if (w !== int'(wc) || !h || c !== 2'(1 << a[0]) || la !== a[12:1]) begin
        errors++; $display("FAIL rand_timing%0d: waits=%0d held=%b cs=%b addr=%h, want %0d 1 %b %h", n, w, h, c, la, wc, 2'(1 << a[0]), a[12:1]);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 8192; i++) begin m_data[i] = '0; m_ev[i] = '1; m_bad[i] = '0; end
    test_reset;
    test_basic;
    test_wait;
    test_back_to_back;
    test_parity;
    test_byte_write;
    test_reset_in_wait;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tcm_bankctl.md
Name: tcm_bankctl

Overview:
- Parametrised successor TCM access controller: one Cortex-M7 TCM host port feeding NB interleaved SRAM banks.
- Adds programmable per-access wait states, per-byte parity generation/check with selectable polarity, and error reporting.
- Sits between the CM7 TCM interface and the hard SRAM macros; banks store 9 bits per byte (8 data + 1 parity).

Parameters:
- AW, 13, host word-address width.
- DW, 32, host data width; multiple of 8.
- NB, 2, bank count; power of two, 1..8; BW = $clog2(NB), 0 when NB=1.
- RDW, 2, waitcyc_i width.
- PW, DW/8, parity bits per word (derived; do not override).

Ports:
- clk  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- even_i  in  1  1 = even parity, 0 = odd parity.
- waitcyc_i  in  RDW  extra data-phase cycles per access; sampled at address phase.
- cs_i  in  1  host access request (address phase).
- addr_i  in  AW  host word address.
- we_i  in  DW/8  byte write enables; 0 = read.
- wd_i  in  DW  host write data.
- rd_o  out  DW  read data, valid when data phase is done.
- wait_o  out  1  data-phase stall.
- err_o  out  1  parity error on the completing read.
- ram_cs_o  out  NB  one-hot bank select.
- ram_addr_o  out  AW-BW  bank-local address.
- ram_we_o  out  DW/8  byte write enables.
- ram_wd_o  out  DW+PW  write data, 9 bits per byte: {byte, parity}.
- ram_rd_i  in  NB*(DW+PW)  concatenated bank read data, 1-cycle synchronous SRAM.

Behaviour:
- Reset (async, any state): FSM = IDLE; wait counter 0; captured regs 0; rd_o = 0, wait_o = 0, err_o = 0, ram_cs_o = 0.
- Decode: bank = addr_i[BW-1:0]; ram_addr_o = addr_i[AW-1:BW]. Interleaved, so consecutive words hit different banks.
- Parity per byte: even_i=1 gives ^byte; even_i=0 gives ~^byte.
- FSM states:
  - IDLE: cs_i=1 drives the RAM combinationally in the same cycle (address phase) and captures bank, read flag, waitcyc_i and even_i. Next state is DATA if waitcyc_i==0, else WAIT with cnt=waitcyc_i.
  - WAIT: RAM re-driven from captured regs, so the SRAM stays selected with stable inputs. wait_o=1; cnt decrements each cycle; cnt==1 goes to DATA.
  - DATA: wait_o=0. For reads, rd_o = stripped data from the captured bank and err_o = OR of byte parity mismatches. For writes, rd_o=0 and err_o=0.
  - From DATA: cs_i=1 overlaps the next address phase (back-to-back, zero bubble); otherwise return to IDLE.
- Latency: waitcyc=0 gives data 1 cycle after cs_i with throughput 1/cycle; waitcyc=N gives data N+1 cycles after cs_i with throughput 1/(N+1).
- cs_i is ignored while wait_o=1; the host holds it per TCM protocol.
- rd_o is 0 and err_o is 0 in every cycle that is not a read DATA cycle.
- waitcyc_i or even_i changing mid-access has no effect until the next address phase.
- Partial-byte writes update only the selected bytes and their parity bits; no read-modify-write.

Optional Feature:
- Macro TCM_BANKCTL_SCRUB_EN.
- When defined, adds these ports:
  - scrub_en_i in 1.
  - scrub_errcnt_o out 16: saturating at 0xFFFF.
  - scrub_erraddr_o out AW: address of the first error; cleared only by reset.
  - scrub_wrap_o out 1: one-cycle pulse.
- Scrubber issues one read at a free-running AW-bit address counter in any cycle that meets all of: IDLE or DATA, cs_i=0, scrub_en_i=1, waitcyc_i==0.
- The host always wins, because the scrubber issues only when cs_i=0.
- The scrub result is checked in the next cycle. It does not drive rd_o or err_o.
- scrub_wrap_o pulses when the counter rolls from 2^AW-1 to 0.
- When the macro is undefined: the ports are absent and the RAM is accessed only by the host.

Test Plan:
- NB=2, waitcyc=0, even=1: write 0xA5A5_0001 @0x10, then read @0x10 -> ram_cs_o=2'b01, ram_addr_o=0x8, rd_o=0xA5A5_0001 one cycle after cs, wait_o never 1, err_o=0.
- waitcyc=3: read @0x11 -> wait_o=1 for exactly 3 cycles, rd_o valid in 4th cycle after cs, ram_cs_o=2'b10 held all 4 cycles.
- Back-to-back reads @0,@1,@2,@3 with waitcyc=0 -> 4 results on 4 consecutive cycles, alternating banks, no bubble.
- Bank model flips the parity bit of byte 2 @0x20; read -> err_o=1 for that single DATA cycle and data still returned. Repeat with even=0 after writing with even=0 -> err_o=0.
- Byte write we_i=4'b0100 wd_i=0x00FF_0000 over 0x1122_3344 -> read 0x11FF_3344, err_o=0.
- Reset asserted during WAIT (waitcyc=3) -> outputs 0 immediately; the next cs_i after release completes normally. With TCM_BANKCTL_SCRUB_EN, AW=4, one corrupted word -> scrub_errcnt_o increments once per wrap, scrub_erraddr_o=corrupt address, scrub_wrap_o every 16 idle cycles.
